// File: rtl/key_param_pkg.sv
// key_param_pkg: shared types, parameter tables and helpers for key_param_ctrl.
//   NUM_PARAM      number of adjustable parameters
//   PARAM_MIN/MAX  inclusive value range per parameter index
//   PARAM_RST      value loaded at reset and broadcast during initialisation
//   state_e        controller FSM states
//   step_value     wrap-around increment/decrement of one parameter
package key_param_pkg;

   localparam int unsigned NUM_PARAM = 4;
   localparam int unsigned PARAM_W   = 5;
   localparam int unsigned IDX_W     = 2;

   typedef logic [PARAM_W-1:0] param_t;
   typedef logic [IDX_W-1:0]   idx_t;

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_SEND
   } state_e;

   // Packed tables, listed idx3 down to idx0.
   localparam param_t [NUM_PARAM-1:0] PARAM_MIN = {5'd10, 5'd1,  5'd0,  5'd10};
   localparam param_t [NUM_PARAM-1:0] PARAM_MAX = {5'd20, 5'd16, 5'd31, 5'd20};
   localparam param_t [NUM_PARAM-1:0] PARAM_RST = {5'd15, 5'd1,  5'd0,  5'd10};

   // Up wraps MAX->MIN, down wraps MIN->MAX.
   function automatic param_t step_value(input idx_t idx, input param_t val, input logic up);
      param_t res;
      if (up) begin
         res = (val == PARAM_MAX[idx]) ? PARAM_MIN[idx] : param_t'(val + 1'b1);
      end else begin
         res = (val == PARAM_MIN[idx]) ? PARAM_MAX[idx] : param_t'(val - 1'b1);
      end
      return res;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one active-low key -> 2-FF synchronizer -> debouncer -> press event.
//   clk, rst_n   clock, asynchronous active-low reset
//   key_n        raw asynchronous key, pressed = 0
//   key_evt      one-cycle pulse per accepted press (plus auto-repeat pulses)
// Optional feature macro: KEY_PARAM_AUTO_REPEAT_EN. When defined, a key held debounced-low
// for HOLD_CYCLES emits a repeat pulse, then one every REP_CYCLES until release; REP_EN=0
// disables repeat for this instance. When undefined, the hold/repeat counters are not built.
module key_debounce #(
   parameter int unsigned DEB_CYCLES  = 1000000,
   parameter int unsigned HOLD_CYCLES = 25000000,
   parameter int unsigned REP_CYCLES  = 5000000,
   parameter bit          REP_EN      = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_evt
);

   localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             deb_q, deb_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             evt_q, evt_d;
   logic             rpt_fire;

   always_comb begin
      sync_d    = {sync_q[0], key_n};
      deb_d     = deb_q;
      deb_cnt_d = '0;
      // Count consecutive samples that differ from the accepted level; any agreeing
      // sample restarts the count.
      if (sync_q[1] != deb_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_d = sync_q[1];
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
      evt_d = (deb_q & ~deb_d) | rpt_fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         deb_q     <= 1'b1;
         deb_cnt_q <= '0;
         evt_q     <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         deb_q     <= deb_d;
         deb_cnt_q <= deb_cnt_d;
         evt_q     <= evt_d;
      end
   end

`ifdef KEY_PARAM_AUTO_REPEAT_EN
   localparam int unsigned RPT_MAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
   localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
   localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REP_CYCLES - 1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_run_q, rpt_run_d;

   // rpt_run_q selects the period: first the hold delay, then the repeat period.
   always_comb begin
      rpt_cnt_d = '0;
      rpt_run_d = 1'b0;
      rpt_fire  = 1'b0;
      if (REP_EN && !deb_q) begin
         rpt_run_d = rpt_run_q;
         if (rpt_cnt_q == (rpt_run_q ? REP_LAST : HOLD_LAST)) begin
            rpt_fire  = 1'b1;
            rpt_run_d = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt_q <= '0;
         rpt_run_q <= 1'b0;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
         rpt_run_q <= rpt_run_d;
      end
   end
`else
   logic unused_rpt_cfg;
   assign unused_rpt_cfg = ^{HOLD_CYCLES, REP_CYCLES, REP_EN};
   assign rpt_fire       = 1'b0;
`endif

   assign key_evt = evt_q;

endmodule

// File: rtl/key_param_ctrl.sv
// key_param_ctrl: three-key editor for four 5-bit parameters with a valid/ready cfg output.
//   clk, rst_n                 clock, asynchronous active-low reset
//   key_up, key_dn, key_sel    raw active-low keys
//   cfg_ready                  downstream accepts the pending cfg word
//   cfg_valid/addr/data        pending cfg word (index, value)
//   sel_idx, cur_value         selected parameter and its current value
//   busy                       FSM not idle
// After reset every parameter is broadcast once with its reset value. An up/down event in
// idle steps the selected parameter and sends it; events outside idle are dropped.
// Optional feature macro: KEY_PARAM_AUTO_REPEAT_EN (auto-repeat on held up/down keys).
module key_param_ctrl
   import key_param_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = 1000000,
   parameter int unsigned HOLD_CYCLES = 25000000,
   parameter int unsigned REP_CYCLES  = 5000000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_up,
   input  logic         key_dn,
   input  logic         key_sel,
   input  logic         cfg_ready,
   output logic         cfg_valid,
   output logic [1:0]   cfg_addr,
   output logic [4:0]   cfg_data,
   output logic [1:0]   sel_idx,
   output logic [4:0]   cur_value,
   output logic         busy
);

   logic up_evt, dn_evt, sel_evt;

   key_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .REP_CYCLES  (REP_CYCLES),
      .REP_EN      (1'b1)
   ) u_deb_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n   (key_up),
      .key_evt (up_evt)
   );

   key_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .REP_CYCLES  (REP_CYCLES),
      .REP_EN      (1'b1)
   ) u_deb_dn (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n   (key_dn),
      .key_evt (dn_evt)
   );

   key_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .REP_CYCLES  (REP_CYCLES),
      .REP_EN      (1'b0)
   ) u_deb_sel (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n   (key_sel),
      .key_evt (sel_evt)
   );

   state_e                      state_q, state_d;
   param_t [NUM_PARAM-1:0]      params_q, params_d;
   idx_t                        sel_q, sel_d;
   logic                        cfg_valid_q, cfg_valid_d;
   idx_t                        cfg_addr_q, cfg_addr_d;
   param_t                      cfg_data_q, cfg_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         params_q    <= PARAM_RST;
         sel_q       <= '0;
         cfg_valid_q <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         params_q    <= params_d;
         sel_q       <= sel_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
      end
   end

   always_comb begin
      logic   step_up, step_dn;
      idx_t   init_nxt;
      param_t new_val;

      state_d     = state_q;
      params_d    = params_q;
      sel_d       = sel_q;
      cfg_valid_d = cfg_valid_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      // Simultaneous up and down cancel each other.
      step_up     = up_evt & ~dn_evt;
      step_dn     = dn_evt & ~up_evt;
      init_nxt    = cfg_addr_q + 1'b1;
      new_val     = step_value(sel_q, params_q[sel_q], step_up);

      unique case (state_q)
         // cfg_addr doubles as the broadcast index; it is 0 out of reset.
         S_INIT: begin
            if (!cfg_valid_q) begin
               cfg_valid_d = 1'b1;
               cfg_data_d  = PARAM_RST[cfg_addr_q];
            end else if (cfg_ready) begin
               if (cfg_addr_q == idx_t'(NUM_PARAM - 1)) begin
                  cfg_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  cfg_addr_d = init_nxt;
                  cfg_data_d = PARAM_RST[init_nxt];
               end
            end
         end
         S_IDLE: begin
            if (sel_evt) begin
               sel_d = sel_q + 1'b1;
            end else if (step_up || step_dn) begin
               params_d[sel_q] = new_val;
               cfg_valid_d     = 1'b1;
               cfg_addr_d      = sel_q;
               cfg_data_d      = new_val;
               state_d         = S_SEND;
            end
         end
         S_SEND: begin
            if (cfg_ready) begin
               cfg_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   assign cfg_valid = cfg_valid_q;
   assign cfg_addr  = cfg_addr_q;
   assign cfg_data  = cfg_data_q;
   assign sel_idx   = sel_q;
   assign cur_value = params_q[sel_q];
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_key_param_ctrl.sv
// tb_key_param_ctrl: self-checking bench for key_param_ctrl with short debounce/repeat timing.
// Expected cfg words are queued when a key action is driven and popped as words are accepted.
module tb_key_param_ctrl;

   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 20;
   localparam int unsigned REP  = 5;
   localparam int          NVEC = 16;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       key_up    = 1'b1;
   logic       key_dn    = 1'b1;
   logic       key_sel   = 1'b1;
   logic       cfg_ready = 1'b1;
   logic       cfg_valid;
   logic [1:0] cfg_addr;
   logic [4:0] cfg_data;
   logic [1:0] sel_idx;
   logic [4:0] cur_value;
   logic       busy;

   always #5 clk = ~clk;

   key_param_ctrl #(
      .DEB_CYCLES  (DEB),
      .HOLD_CYCLES (HOLD),
      .REP_CYCLES  (REP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_up    (key_up),
      .key_dn    (key_dn),
      .key_sel   (key_sel),
      .cfg_ready (cfg_ready),
      .cfg_valid (cfg_valid),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .sel_idx   (sel_idx),
      .cur_value (cur_value),
      .busy      (busy)
   );

   // keys: bit0 up, bit1 down, bit2 sel (1 = pressed)
   typedef struct {
      logic [2:0] keys;
      logic       exp_word;
      logic [1:0] exp_addr;
      logic [4:0] exp_data;
      logic [1:0] exp_sel;
      logic [4:0] exp_cur;
   } vec_t;

   vec_t       vecs[NVEC];
   int         checks = 0;
   int         errors = 0;
   logic [6:0] exp_q[$];
   logic       hold_pend = 1'b0;
   logic [6:0] held_word = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Called once per cycle mid-period: stability while stalled, scoreboard on transfer.
   task automatic monitor();
      if (rst_n && cfg_valid) begin
         if (hold_pend) chk("cfg_stable", 32'({cfg_addr, cfg_data}), 32'(held_word));
         if (cfg_ready) begin
            hold_pend = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cfg_word: got unexpected (%0d,%0d), want none", cfg_addr, cfg_data);
            end else begin
               chk("cfg_word", 32'({cfg_addr, cfg_data}), 32'(exp_q.pop_front()));
            end
         end else begin
            hold_pend = 1'b1;
            held_word = {cfg_addr, cfg_data};
         end
      end else begin
         hold_pend = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic set_keys(input logic [2:0] m);
      key_up  = ~m[0];
      key_dn  = ~m[1];
      key_sel = ~m[2];
   endtask

   task automatic press(input logic [2:0] m, input int low);
      set_keys(m);
      repeat (low) step();
      set_keys(3'b000);
      repeat (12) step();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) step();
      chk("idle", 32'(busy), 0);
   endtask

   task automatic push_init();
      exp_q.push_back({2'd0, 5'd10});
      exp_q.push_back({2'd1, 5'd0});
      exp_q.push_back({2'd2, 5'd1});
      exp_q.push_back({2'd3, 5'd15});
   endtask

   // Caller is at posedge+1 with rst_n low.
   task automatic do_init();
      rst_n = 1'b1;
      @(negedge clk);
      chk("valid_pre_edge", 32'(cfg_valid), 0);
      monitor();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("first_valid", 32'(cfg_valid), 1);
      chk("first_addr", 32'(cfg_addr), 0);
      chk("first_data", 32'(cfg_data), 10);
      monitor();
      @(posedge clk);
      #1;
      repeat (3) step();
      @(negedge clk);
      chk("init_busy", 32'(busy), 0);
      chk("init_valid", 32'(cfg_valid), 0);
      monitor();
      @(posedge clk);
      #1;
      chk("init_drained", 32'(exp_q.size()), 0);
   endtask

   initial begin
      vecs[0]  = '{3'b001, 1'b1, 2'd0, 5'd11, 2'd0, 5'd11};
      vecs[1]  = '{3'b010, 1'b1, 2'd0, 5'd10, 2'd0, 5'd10};
      vecs[2]  = '{3'b010, 1'b1, 2'd0, 5'd20, 2'd0, 5'd20};
      vecs[3]  = '{3'b001, 1'b1, 2'd0, 5'd10, 2'd0, 5'd10};
      vecs[4]  = '{3'b100, 1'b0, 2'd0, 5'd0,  2'd1, 5'd0};
      vecs[5]  = '{3'b001, 1'b1, 2'd1, 5'd1,  2'd1, 5'd1};
      vecs[6]  = '{3'b011, 1'b0, 2'd0, 5'd0,  2'd1, 5'd1};
      vecs[7]  = '{3'b010, 1'b1, 2'd1, 5'd0,  2'd1, 5'd0};
      vecs[8]  = '{3'b010, 1'b1, 2'd1, 5'd31, 2'd1, 5'd31};
      vecs[9]  = '{3'b100, 1'b0, 2'd0, 5'd0,  2'd2, 5'd1};
      vecs[10] = '{3'b010, 1'b1, 2'd2, 5'd16, 2'd2, 5'd16};
      vecs[11] = '{3'b001, 1'b1, 2'd2, 5'd1,  2'd2, 5'd1};
      vecs[12] = '{3'b100, 1'b0, 2'd0, 5'd0,  2'd3, 5'd15};
      vecs[13] = '{3'b001, 1'b1, 2'd3, 5'd16, 2'd3, 5'd16};
      vecs[14] = '{3'b100, 1'b0, 2'd0, 5'd0,  2'd0, 5'd10};
      vecs[15] = '{3'b101, 1'b0, 2'd0, 5'd0,  2'd1, 5'd31};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(cfg_valid), 0);
      chk("rst_addr", 32'(cfg_addr), 0);
      chk("rst_data", 32'(cfg_data), 0);
      chk("rst_sel", 32'(sel_idx), 0);
      chk("rst_cur", 32'(cur_value), 10);
      chk("rst_busy", 32'(busy), 1);

      push_init();
      do_init();

      // Single-key actions
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].exp_word) exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
         press(vecs[i].keys, 10);
         wait_idle();
         chk($sformatf("vec%0d_sel", i), 32'(sel_idx), 32'(vecs[i].exp_sel));
         chk($sformatf("vec%0d_cur", i), 32'(cur_value), 32'(vecs[i].exp_cur));
         chk($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 0);
      end

      // Bouncing up key on idx1 (31) yields exactly one step: wrap to 0
      exp_q.push_back({2'd1, 5'd0});
      for (int i = 0; i < 15; i++) begin
         key_up = ~key_up;
         step();
         step();
      end
      key_up = 1'b0;
      repeat (10) step();
      key_up = 1'b1;
      repeat (12) step();
      wait_idle();
      chk("bounce_cur", 32'(cur_value), 0);
      chk("bounce_drained", 32'(exp_q.size()), 0);

      // Stalled downstream: second press during the stall is dropped
      exp_q.push_back({2'd1, 5'd1});
      cfg_ready = 1'b0;
      press(3'b001, 10);
      chk("stall_busy", 32'(busy), 1);
      press(3'b001, 10);
      repeat (10) step();
      chk("stall_valid", 32'(cfg_valid), 1);
      chk("stall_data", 32'(cfg_data), 1);
      cfg_ready = 1'b1;
      step();
      wait_idle();
      chk("stall_cur", 32'(cur_value), 1);
      chk("stall_drained", 32'(exp_q.size()), 0);

      // Reset while a word is pending: word is lost, init sequence restarts
      cfg_ready = 1'b0;
      press(3'b001, 10);
      chk("pend_valid", 32'(cfg_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(cfg_valid), 0);
      @(posedge clk);
      #1;
      repeat (2) step();
      cfg_ready = 1'b1;
      push_init();
      do_init();
      chk("midrst_sel", 32'(sel_idx), 0);
      chk("midrst_cur", 32'(cur_value), 10);

      // Long hold on idx1
      press(3'b100, 10);
      wait_idle();
      chk("hold_sel", 32'(sel_idx), 1);
      chk("hold_cur0", 32'(cur_value), 0);
`ifdef KEY_PARAM_AUTO_REPEAT_EN
      for (int v = 1; v <= 5; v++) exp_q.push_back({2'd1, 5'(v)});
      press(3'b001, 39);
      wait_idle();
      chk("repeat_cur", 32'(cur_value), 5);
`else
      exp_q.push_back({2'd1, 5'd1});
      press(3'b001, 39);
      wait_idle();
      chk("hold_cur", 32'(cur_value), 1);
`endif
      chk("final_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_param_ctrl.md
KEY_PARAM_CTRL -- requirements
Module: key_param_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, consecutive stable samples needed to accept a key level (20 ms at 50 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000, debounced-low time before auto-repeat starts.
REQ-003 SHALL have parameter REP_CYCLES, default 5000000, auto-repeat event period.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_up / key_dn / key_sel  input  1 each  raw asynchronous keys, active-low (pressed = 0).
REQ-007 cfg_ready  input  1  downstream accepts cfg word when high with cfg_valid.
REQ-008 cfg_valid  output  1  cfg word pending.
REQ-009 cfg_addr  output  2  parameter index of pending word.
REQ-010 cfg_data  output  5  parameter value of pending word.
REQ-011 sel_idx  output  2  currently selected parameter.
REQ-012 cur_value  output  5  value of selected parameter.
REQ-013 busy  output  1  high whenever FSM is not in S_IDLE.

Function
REQ-014 Each key SHALL pass a 2-FF synchronizer, then a debouncer changing level only after DEB_CYCLES equal consecutive samples.
REQ-015 Press event SHALL be a 1-cycle pulse on debounced 1->0 transition; release generates nothing.
REQ-016 Four 5-bit parameters SHALL be held with per-index MIN/MAX/RST: idx0 10/20/10, idx1 0/31/0, idx2 1/16/1, idx3 10/20/15.
REQ-017 Up event: value = MAX ? MIN : value+1 on selected parameter; down event: value = MIN ? MAX : value-1.
REQ-018 Sel event: sel_idx <= sel_idx+1 mod 4; no cfg word issued.
REQ-019 Same-cycle up and down events SHALL both be dropped; sel in same cycle as up/down SHALL win and the step is dropped.
REQ-020 FSM states S_INIT, S_IDLE, S_SEND.
REQ-021 S_INIT: issue cfg words for idx 0..3 in order with RST values, each held until cfg_ready; after idx3 accepted -> S_IDLE.
REQ-022 S_IDLE: up/down event updates parameter next cycle and asserts cfg_valid with that addr/data same cycle -> S_SEND.
REQ-023 S_SEND: cfg_addr/cfg_data SHALL stay stable while cfg_valid high; cfg_valid && cfg_ready -> cfg_valid low next cycle, -> S_IDLE.
REQ-024 All up/down/sel events arriving outside S_IDLE SHALL be dropped, not queued.
REQ-025 cur_value SHALL track parameter[sel_idx] combinationally from registered state.

Reset
REQ-026 During reset: state S_INIT, cfg_valid 0, cfg_addr 0, cfg_data 0, sel_idx 0, parameters at RST, debounced levels 1, counters 0.
REQ-027 First posedge after rst_n release SHALL assert cfg_valid with addr 0, data 10.
REQ-028 Reset asserted mid-handshake SHALL immediately clear cfg_valid and restart the S_INIT sequence on release.

Configuration
REQ-029 Macro KEY_PARAM_AUTO_REPEAT_EN defined: up/dn held debounced-low for HOLD_CYCLES generate first repeat event, then one every REP_CYCLES until release; sel never repeats.
REQ-030 Macro undefined: exactly one event per press; hold/repeat counters not built.

Structure
REQ-031 Package key_param_pkg SHALL hold NUM_PARAM=4, PARAM_MIN/MAX/RST tables, state enum.
REQ-032 Sub-module key_debounce (sync, debounce, press pulse, optional repeat) SHALL be instantiated three times.

Verification (DEB_CYCLES=4, HOLD_CYCLES=20, REP_CYCLES=5)
REQ-033 Release reset, cfg_ready=1 -> words (0,10),(1,0),(2,1),(3,15) on consecutive cycles, then busy=0.
REQ-034 idx0=20, one up press -> cfg word (0,10); idx0=10, one down press -> (0,20).
REQ-035 Key bounce 0/1 toggling every 2 cycles for 30 cycles then stable low -> exactly one event.
REQ-036 cfg_ready held low 50 cycles after up press, second up press meanwhile -> single word, value +1 only, data stable.
REQ-037 Sel press then up press -> sel_idx=1, word (1,1); up and down pressed same cycle -> no word.
REQ-038 With KEY_PARAM_AUTO_REPEAT_EN, hold up on idx1 for 4+20+15 cycles -> 1 press + 4 repeat words, values 1..5.
